// File: rtl/lbc_stream_encoder.sv
// Streaming systematic linear block encoder.
// Encodes K-bit data words into N-bit codewords when they are accepted, buffers up to two
// codewords, and emits them either as parallel words or bit-serially (MSB first).
module lbc_stream_encoder #(
  parameter int unsigned          K           = 4,
  parameter int unsigned          N           = 14,
  parameter logic [(N-K)*K-1:0]   PARITY_MASK = 40'hDCBA976531,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  input  logic             mode_serial,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_word,
  output logic             out_bit,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned P     = N - K;
  localparam int unsigned IDX_W = $clog2(N);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Data bits on top, parity bit j is the XOR of the data bits selected by mask slice j.
  function automatic logic [N-1:0] encode(input logic [K-1:0] b);
    logic [N-1:0] c;
    c = '0;
    c[N-1 -: K] = b;
    for (int j = 0; j < P; j++) begin
      c[j] = ^(b & PARITY_MASK[j*K +: K]);
    end
    return c;
  endfunction

  logic [N-1:0]     mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             mode_q, mode_d;
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] word_count_q;
  logic             ready_en_q;

  logic         push, pop, xfer, last_bit;
  logic [N-1:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign busy      = (occ_q != 2'd0);
  // ready_en_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = ready_en_q & (occ_q != 2'd2);
  assign push      = in_valid & in_ready;
  assign out_valid = mode_q ? (state_q == S_SHIFT) : busy;
  assign xfer      = out_valid & out_ready;
  assign last_bit  = (idx_q == IDX_W'(0));
  assign pop       = xfer & (~mode_q | last_bit);

  assign out_word   = out_valid ? head : '0;
  assign out_bit    = mode_q & out_valid & head[idx_q];
  assign out_sop    = mode_q & out_valid & (idx_q == IDX_W'(N - 1));
  assign out_eop    = mode_q & out_valid & last_bit;
  assign word_count = word_count_q;

  // Next-state for occupancy, serial index, FSM and run-time mode.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    idx_d = idx_q;
    if (mode_q && xfer) begin
      idx_d = last_bit ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
    end

    // Mode can only change while drained, so mode_q is the mode of any word still buffered.
    state_d = (mode_q && (occ_d != 2'd0)) ? S_SHIFT : S_IDLE;

    mode_d = (!busy && !push) ? mode_serial : mode_q;
  end

  // Buffer storage, pointers and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      mode_q       <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= IDX_W'(N - 1);
      word_count_q <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= encode(in_data);
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q     <= ~rd_ptr_q;
        word_count_q <= word_count_q + CNT_W'(1);
      end
      occ_q      <= occ_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbc_stream_encoder.sv
// Self-checking bench for lbc_stream_encoder: default (14,4) build, a (12,8) build and a
// 3-bit counter build, against a queue-based reference model.
module tb_lbc_stream_encoder;

  localparam logic [39:0] MASK1 = 40'hDCBA976531;
  localparam logic [31:0] MASK2 = 32'h5A3C96E1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        in_valid = 1'b0, in_ready, mode_serial = 1'b0, out_valid, out_ready = 1'b0;
  logic [3:0]  in_data = '0;
  logic [13:0] out_word;
  logic        out_bit, out_sop, out_eop, busy;
  logic [15:0] word_count;

  // K=8, N=12 build
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_bit2, out_sop2, out_eop2, busy2;
  logic [7:0]  in_data2 = '0;
  logic [11:0] out_word2;
  logic [15:0] word_count2;

  // CNT_W=3 build
  logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_bit3, out_sop3, out_eop3, busy3;
  logic [3:0]  in_data3 = '0;
  logic [13:0] out_word3;
  logic [2:0]  word_count3;

  lbc_stream_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode_serial(mode_serial), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_bit(out_bit), .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .word_count(word_count)
  );

  lbc_stream_encoder #(.K(8), .N(12), .PARITY_MASK(MASK2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .mode_serial(1'b0), .out_valid(out_valid2), .out_ready(1'b1),
    .out_word(out_word2), .out_bit(out_bit2), .out_sop(out_sop2), .out_eop(out_eop2),
    .busy(busy2), .word_count(word_count2)
  );

  lbc_stream_encoder #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .mode_serial(1'b0), .out_valid(out_valid3), .out_ready(1'b1),
    .out_word(out_word3), .out_bit(out_bit3), .out_sop(out_sop3), .out_eop(out_eop3),
    .busy(busy3), .word_count(word_count3)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [13:0] word;
    logic        obit;
    logic        sop;
    logic        eop;
    logic        busy;
    logic [15:0] cnt;
  } obs_t;

  // Reference model: queue of codewords, bits already sent of the head, mode, counter.
  logic [13:0] mq[$];
  int          msent;
  logic        mmode;
  logic [15:0] mcnt;
  logic        mready_en;

  // Codeword straight from the code definition: data on top, parity j = parity of masked bits.
  function automatic logic [15:0] encode_ref(input int k, input int n, input logic [63:0] mask,
                                             input logic [15:0] b);
    logic [15:0] c;
    logic [15:0] sl;
    c = b << (n - k);
    for (int j = 0; j < n - k; j++) begin
      sl = 16'((mask >> (j * k)) & ((64'd1 << k) - 64'd1));
      c[j] = ($countones(b & sl) % 2) == 1;
    end
    return c;
  endfunction

  function automatic logic model_in_ready();
    return mready_en && (mq.size() < 2);
  endfunction

  function automatic obs_t model_obs();
    obs_t        o;
    logic [13:0] w;
    o = '0;
    o.in_ready  = model_in_ready();
    o.out_valid = mq.size() > 0;
    o.busy      = o.out_valid;
    o.cnt       = mcnt;
    if (o.out_valid) begin
      w      = mq[0];
      o.word = w;
      if (mmode) begin
        o.obit = w[13 - msent];
        o.sop  = (msent == 0);
        o.eop  = (msent == 13);
      end
    end
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return {in_ready, out_valid, out_word, out_bit, out_sop, out_eop, busy, word_count};
  endfunction

  task automatic model_reset();
    mq.delete();
    msent     = 0;
    mmode     = 1'b0;
    mcnt      = '0;
    mready_en = 1'b0;
  endtask

  // Apply inputs half a cycle before the edge; outputs are checked after they settle.
  task automatic drive(input logic iv, input logic [3:0] d, input logic ordy, input logic ms);
    @(negedge clk);
    in_valid    = iv;
    in_data     = d;
    out_ready   = ordy;
    mode_serial = ms;
    #1;
  endtask

  // Advance the model by one clock edge using the currently applied inputs, then take the edge.
  task automatic advance();
    logic was_empty, push;
    was_empty = (mq.size() == 0);
    push      = in_valid && model_in_ready();
    if (!was_empty && out_ready) begin
      if (!mmode) begin
        void'(mq.pop_front());
        mcnt++;
      end else if (msent == 13) begin
        void'(mq.pop_front());
        msent = 0;
        mcnt++;
      end else begin
        msent++;
      end
    end
    if (push) mq.push_back(14'(encode_ref(4, 14, 64'(MASK1), 16'(in_data))));
    if (was_empty && !push) mmode = mode_serial;
    mready_en = 1'b1;
    @(posedge clk);
  endtask

  // Drain the block and latch the requested mode.
  task automatic settle(input logic ms);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 4'h0, 1'b1, ms);
      advance();
      if (mq.size() == 0 && mmode == ms) break;
    end
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (dut_obs() !== zero) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", dut_obs(), zero);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    advance();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    n_cmp++;
    if (dut_obs() !== model_obs() || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %h expected %h", dut_obs(), model_obs());
    end
    advance();
  endtask

  task automatic test_parallel();
    logic [3:0]  din  [3] = '{4'hB, 4'hF, 4'h0};
    logic [13:0] wexp [3] = '{14'h2D8D, 14'h3E91, 14'h0000};
    logic [15:0] c0;
    settle(1'b0);
    for (int i = 0; i < 3; i++) begin
      c0 = mcnt;
      drive(1'b1, din[i], 1'b1, 1'b0);
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL parallel_push[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      advance();
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_word !== wexp[i]) begin
        n_fail++;
        $display("FAIL parallel_word[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_word,
                 wexp[i]);
      end
      advance();
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      n_cmp++;
      if (word_count !== c0 + 16'd1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL parallel_count[%0d]: got %0d v=%b expected %0d v=0", i, word_count,
                 out_valid, c0 + 16'd1);
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0]  w [3] = '{4'h3, 4'hC, 4'h9};
    logic [13:0] got [3];
    int pushed, pops, acc3;
    settle(1'b0);
    pushed = 0;
    pops   = 0;
    acc3   = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive(pushed < 3, (pushed < 3) ? w[pushed] : 4'h0, cyc >= 4, 1'b0);
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL bp_cycle[%0d]: got %h expected %h", cyc, dut_obs(), model_obs());
      end
      if (cyc == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full_ready: got %b expected 0", in_ready);
        end
      end
      if (mq.size() > 0 && out_ready && pops < 3) begin
        got[pops] = out_word;
        pops++;
      end
      if (in_valid && model_in_ready()) begin
        if (pushed == 2) acc3 = cyc;
        pushed++;
      end
      advance();
    end
    n_cmp++;
    if (acc3 !== 5) begin
      n_fail++;
      $display("FAIL bp_third_accept: got cycle %0d expected 5", acc3);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== 14'(encode_ref(4, 14, 64'(MASK1), 16'(w[i])))) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i],
                 14'(encode_ref(4, 14, 64'(MASK1), 16'(w[i]))));
      end
    end
  endtask

  task automatic test_serial();
    logic [13:0] seq;
    settle(1'b1);
    seq = '0;
    for (int i = 0; i < 30; i++) begin
      drive(i < 2, (i == 0) ? 4'hB : 4'h5, 1'b1, 1'b1);
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL serial_cycle[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      if (i >= 1 && i <= 28) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_sop !== (i == 1 || i == 15) ||
            out_eop !== (i == 14 || i == 28)) begin
          n_fail++;
          $display("FAIL serial_framing[%0d]: got v=%b sop=%b eop=%b", i, out_valid, out_sop,
                   out_eop);
        end
        if (i <= 14) seq = {seq[12:0], out_bit};
      end
      advance();
    end
    n_cmp++;
    if (seq !== 14'b10110110001101) begin
      n_fail++;
      $display("FAIL serial_bits: got %b expected 10110110001101", seq);
    end
  endtask

  task automatic test_stall_mode();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL stall_cycle[%0d]: got %h expected %h mode=%b", i, dut_obs(), model_obs(),
                 mmode);
      end
      advance();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL stall_drain[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    obs_t zero;
    zero = '0;
    settle(1'b1);
    drive(1'b1, 4'hB, 1'b1, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1);
      advance();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_obs() !== zero) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected %h", dut_obs(), zero);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    advance();
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    advance();
    drive(1'b1, 4'h6, 1'b1, 1'b1);
    advance();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1);
      n_cmp++;
      if (dut_obs() !== model_obs() || (i == 0 && out_sop !== 1'b1)) begin
        n_fail++;
        $display("FAIL midreset_after[%0d]: got %h expected %h", i, dut_obs(), model_obs());
      end
      advance();
    end
  endtask

  task automatic test_exhaustive();
    settle(1'b0);
    for (int b = 0; b <= 16; b++) begin
      drive(b < 16, 4'(b), 1'b1, 1'b0);
      n_cmp++;
      if (dut_obs() !== model_obs()) begin
        n_fail++;
        $display("FAIL exh_cycle[%0d]: got %h expected %h", b, dut_obs(), model_obs());
      end
      if (b > 0) begin
        n_cmp++;
        if (out_word !== 14'(encode_ref(4, 14, 64'(MASK1), 16'(b - 1)))) begin
          n_fail++;
          $display("FAIL exh_word[%0d]: got %h expected %h", b - 1, out_word,
                   14'(encode_ref(4, 14, 64'(MASK1), 16'(b - 1))));
        end
      end
      advance();
    end
  endtask

  task automatic test_other_build();
    logic [7:0] prev;
    prev = '0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        n_cmp++;
        if (out_valid2 !== 1'b1 ||
            out_word2 !== 12'(encode_ref(8, 12, 64'(MASK2), 16'(prev)))) begin
          n_fail++;
          $display("FAIL k8n12_word[%0d]: got v=%b %h expected %h", i, out_valid2, out_word2,
                   12'(encode_ref(8, 12, 64'(MASK2), 16'(prev))));
        end
      end
      prev      = 8'($urandom);
      in_data2  = prev;
      in_valid2 = (i < 20);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid3 = 1'b1;
      in_data3  = 4'($urandom);
    end
    @(negedge clk);
    in_valid3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (word_count3 !== 3'd1 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %0d busy=%b expected 1 busy=0", word_count3, busy3);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_parallel();
    test_back_pressure();
    test_serial();
    test_stall_mode();
    test_reset_mid();
    test_exhaustive();
    test_other_build();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lbc_stream_encoder.md
Name: lbc_stream_encoder

Overview:
- Parametrised, streaming, systematic linear block encoder. Next generation of the fixed (14,4) combinational encoder.
- Accepts K-bit data words over a valid/ready handshake and computes N-bit codewords from a parameterised parity mask.
- Buffers up to two codewords.
- Emits codewords either as whole parallel words or bit-serially (MSB first), selectable at run time. Sits between the data source and the channel model / decoder bench.

Parameters:
- K, 4, data bits per word (>=2).
- N, 14, codeword bits (N>K).
- PARITY_MASK, 40'hDCBA976531, (N-K)*K bits. Slice j selects the data bits XORed into parity bit j: PARITY_MASK[j*K +: K] for c[j], j=0..N-K-1. Default reproduces the current (14,4) code.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data valid
- in_ready  out  1  encoder can accept a word
- in_data  in  K  data word b
- mode_serial  in  1  0=parallel word output, 1=bit-serial output
- out_valid  out  1  output item (word or bit) valid
- out_ready  in  1  sink accepts output item
- out_word  out  N  head codeword; valid whenever out_valid
- out_bit  out  1  current serial bit (serial mode only, else 0)
- out_sop  out  1  serial: first bit of codeword (c[N-1]); parallel: 0
- out_eop  out  1  serial: last bit (c[0]); parallel: 0
- busy  out  1  buffer non-empty or serialisation in progress
- word_count  out  CNT_W  codewords fully delivered, wraps modulo 2^CNT_W

Behaviour:
- Codeword layout:
  - c[N-1:N-K] = b[K-1:0].
  - c[j] = XOR over i of (b[i] AND PARITY_MASK[j*K+i]) for j<N-K.
  - Encoding happens at input acceptance; the buffer stores full N-bit codewords.
- Reset (rst_n low, async, at any time including mid-word): buffer emptied, bit index = N-1, mode_q=0, word_count=0. All outputs 0: in_ready=0 during reset, 1 on the first clk edge after release.
- Buffer: 2-entry FIFO.
  - in_ready = (occupancy<2). No pass-through: when full, a pop in the same cycle does not raise in_ready until the next cycle.
  - Push on in_valid&in_ready.
  - Latency: push at edge t -> out_valid high after edge t (next cycle) if the buffer was empty.
- mode_q: sampled from mode_serial on any clock edge where busy=0 and no push occurs. Held constant while busy=1. Changing mode_serial mid-stream has no effect until the block drains.
- Parallel mode (mode_q=0):
  - out_valid = occupancy>0.
  - out_word = head.
  - Pop on out_valid&out_ready.
  - Throughput: 1 word/cycle with the buffer non-empty.
- Serial mode (mode_q=1):
  - States: S_IDLE (empty), S_SHIFT.
  - S_SHIFT: out_valid=1, out_bit = head[idx], idx counts N-1 down to 0, decrementing on out_valid&out_ready.
  - out_sop when idx==N-1; out_eop when idx==0.
  - Handshake on eop pops the head and reloads idx=N-1. Next word starts the following cycle with no gap if the buffer is non-empty, else the state returns to S_IDLE.
  - out_ready low stalls all outputs unchanged.
  - The buffer keeps accepting input while shifting.
- word_count increments by 1 on every pop (parallel handshake or serial eop handshake). Wraps from 2^CNT_W-1 to 0.
- Simultaneous push and pop with occupancy 1: occupancy stays 1, the new word becomes head next cycle.
- out_bit, out_sop, out_eop are 0 whenever out_valid=0.

Test Plan:
- Parallel, K=4/N=14 default, send b=4'hB with out_ready=1 -> next cycle out_valid=1, out_word=14'h2D8D, word_count=1. Then b=4'hF -> 14'h3E91. b=4'h0 -> 14'h0000.
- Back-pressure: out_ready=0, push 3 words continuously -> in_ready drops after the 2nd accept, 3rd held. Raise out_ready -> words emerge in order, 3rd accepted one cycle after the first pop, no loss or duplication.
- Serial: mode_serial=1 while idle, push 4'hB -> 14 consecutive bits 1,0,1,1,0,1,1,0,0,0,1,1,0,1. out_sop on the 1st bit, out_eop on the 14th. A second queued word follows with no idle cycle.
- Serial stall and mode change: toggle out_ready randomly and flip mode_serial mid-word -> bit sequence unchanged, mode switches only after busy=0.
- Reset mid-serialisation at bit 5: drive rst_n low asynchronously -> all outputs 0 immediately, word_count=0. After release, the next word encodes correctly from sop.
- Exhaustive: all 16 inputs in parallel mode compared against a reference model. Also a non-default build (K=8, N=12, arbitrary mask) against the model. word_count wrap checked with CNT_W=3 after 9 words -> 1.
